// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate type and sync bundle for the VGA timing path.
package vga_timing_pkg;

    typedef logic [11:0] coord_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bus_t;

    // Sync levels that mean "nothing happening" for a given polarity.
    function automatic sync_bus_t idle_sync(input logic pol);
        sync_bus_t s;
        s.hsync    = ~pol;
        s.vsync    = ~pol;
        s.video_on = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register that re-times sync/video_on to match the display data pipeline.
module sync_delay_line #(
    parameter int unsigned           WIDTH   = 3,
    parameter int unsigned           DEPTH   = 2,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_pipe
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic [WIDTH-1:0] d;
            logic [WIDTH-1:0] q;

            if (i == 0) begin : g_first
                assign d = din;
            end else begin : g_next
                assign d = g_stage[i-1].q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= RST_VAL;
                end else if (en) begin
                    q <= d;
                end
            end
        end
        assign dout = g_stage[DEPTH-1].q;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, line/frame strobes and sync/video_on decode, re-timed to the display pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS_END  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bus_t SYNC_IDLE = idle_sync(SYNC_POL);

    coord_t    x_next;
    coord_t    y_next;
    logic      x_wrap;
    logic      y_wrap;
    sync_bus_t raw_next;
    sync_bus_t raw_q;
    sync_bus_t sync_out;

    always_comb begin
        x_wrap = (xpos == H_LAST);
        y_wrap = (ypos == V_LAST);
        x_next = x_wrap ? '0 : xpos + coord_t'(1);
        y_next = ypos;
        if (x_wrap) begin
            y_next = y_wrap ? '0 : ypos + coord_t'(1);
        end
    end

    // Decode from the coordinates being written, so raw_q lines up with xpos/ypos.
    always_comb begin
        raw_next.hsync    = (x_next >= HS_START && x_next < HS_END) ? SYNC_POL : ~SYNC_POL;
        raw_next.vsync    = (y_next >= VS_START && y_next < VS_END) ? SYNC_POL : ~SYNC_POL;
        raw_next.video_on = (x_next < H_VIS_END) && (y_next < V_VIS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            raw_q       <= SYNC_IDLE;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                xpos        <= x_next;
                ypos        <= y_next;
                raw_q       <= raw_next;
                line_start  <= x_wrap;
                frame_start <= x_wrap && y_wrap;
            end
        end
    end

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (raw_q),
        .dout  (sync_out)
    );

    assign hsync    = sync_out.hsync;
    assign vsync    = sync_out.vsync;
    assign video_on = sync_out.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a reduced-size raster for frame-level cases, and SYNC_POL=1/PIPE_DLY=0.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, en_a, ls_a, fs_a, hs_a, vs_a, vo_a;
    logic [11:0] x_a, y_a;
    logic        rst_n_b, en_b, ls_b, fs_b, hs_b, vs_b, vo_b;
    logic [11:0] x_b, y_b;
    logic        rst_n_c, en_c, ls_c, fs_c, hs_c, vs_c, vo_c;
    logic [11:0] x_c, y_c;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .xpos(x_a), .ypos(y_a),
        .line_start(ls_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a)
    );

    // 15 x 8 raster: hsync raw x 10..12, vsync raw y 5..6, 120 ticks per frame
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .xpos(x_b), .ypos(y_b),
        .line_start(ls_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b)
    );

    vga_timing_gen #(
        .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n_c), .en(en_c), .xpos(x_c), .ypos(y_c),
        .line_start(ls_c), .frame_start(fs_c), .hsync(hs_c), .vsync(vs_c), .video_on(vo_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (2) tick();
        total_cnt += 10;
        if (x_a !== 12'd0) $display("FAIL reset_x: got %0d want 0", x_a); else pass_cnt++;
        if (y_a !== 12'd0) $display("FAIL reset_y: got %0d want 0", y_a); else pass_cnt++;
        if (ls_a !== 1'b0) $display("FAIL reset_ls: got %b want 0", ls_a); else pass_cnt++;
        if (fs_a !== 1'b0) $display("FAIL reset_fs: got %b want 0", fs_a); else pass_cnt++;
        if (vo_a !== 1'b0) $display("FAIL reset_vo: got %b want 0", vo_a); else pass_cnt++;
        if (hs_a !== 1'b1) $display("FAIL reset_hs: got %b want 1", hs_a); else pass_cnt++;
        if (vs_a !== 1'b1) $display("FAIL reset_vs: got %b want 1", vs_a); else pass_cnt++;
        if (hs_c !== 1'b0) $display("FAIL reset_hs_pol1: got %b want 0", hs_c); else pass_cnt++;
        if (vs_c !== 1'b0) $display("FAIL reset_vs_pol1: got %b want 0", vs_c); else pass_cnt++;
        if (vo_c !== 1'b0) $display("FAIL reset_vo_pol1: got %b want 0", vo_c); else pass_cnt++;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        tick();
        total_cnt++;
        if (x_a !== 12'd0) $display("FAIL hold_after_release: x got %0d want 0", x_a); else pass_cnt++;
    endtask

    task automatic test_line_count();
        int unsigned ls_cnt = 0;
        int unsigned hs_low = 0;
        en_a = 1'b1;
        for (int unsigned k = 1; k <= 1700; k++) begin
            logic [11:0] ex, ey;
            logic        els, ehs, evo;
            tick();
            ex  = 12'(k % 800);
            ey  = 12'(k / 800);
            els = (ex == 12'd0);
            ehs = !(ex >= 12'd658 && ex <= 12'd753);
            evo = (k >= 3) && (ex >= 12'd2) && (ex < 12'd642);
            if (ls_a) ls_cnt++;
            if (k <= 800 && !hs_a) hs_low++;
            total_cnt += 6;
            if (x_a !== ex)   $display("FAIL cnt_x k=%0d: got %0d want %0d", k, x_a, ex); else pass_cnt++;
            if (y_a !== ey)   $display("FAIL cnt_y k=%0d: got %0d want %0d", k, y_a, ey); else pass_cnt++;
            if (ls_a !== els) $display("FAIL cnt_ls k=%0d: got %b want %b", k, ls_a, els); else pass_cnt++;
            if (fs_a !== 1'b0) $display("FAIL cnt_fs k=%0d: got %b want 0", k, fs_a); else pass_cnt++;
            if (hs_a !== ehs) $display("FAIL cnt_hs k=%0d x=%0d: got %b want %b", k, x_a, hs_a, ehs); else pass_cnt++;
            if (vo_a !== evo) $display("FAIL cnt_vo k=%0d x=%0d: got %b want %b", k, x_a, vo_a, evo); else pass_cnt++;
        end
        total_cnt += 2;
        if (ls_cnt !== 2)  $display("FAIL line_start_count: got %0d want 2", ls_cnt); else pass_cnt++;
        if (hs_low !== 96) $display("FAIL hsync_width: got %0d want 96", hs_low); else pass_cnt++;
        en_a = 1'b0;
        repeat (3) tick();
        total_cnt += 3;
        if (x_a !== 12'd100) $display("FAIL freeze_x: got %0d want 100", x_a); else pass_cnt++;
        if (y_a !== 12'd2)   $display("FAIL freeze_y: got %0d want 2", y_a); else pass_cnt++;
        if (ls_a !== 1'b0)   $display("FAIL freeze_ls: got %b want 0", ls_a); else pass_cnt++;
    endtask

    task automatic test_frame();
        int unsigned fs_cnt = 0, ls_cnt = 0, vs_low = 0, hs_low = 0, first_vs = 0;
        en_b = 1'b1;
        for (int unsigned k = 1; k <= 365; k++) begin
            logic efs;
            tick();
            efs = (k % 120 == 0);
            if (fs_b) fs_cnt++;
            if (ls_b) ls_cnt++;
            if (k <= 120 && !vs_b) begin
                vs_low++;
                if (first_vs == 0) first_vs = k;
            end
            if (k <= 15 && !hs_b) hs_low++;
            total_cnt++;
            if (fs_b !== efs) $display("FAIL frame_fs k=%0d: got %b want %b", k, fs_b, efs); else pass_cnt++;
            if (k == 121) begin
                total_cnt++;
                if (vo_b !== 1'b0) $display("FAIL frame_vo_pre: got %b want 0", vo_b); else pass_cnt++;
            end
            if (k == 122) begin
                total_cnt++;
                if (vo_b !== 1'b1) $display("FAIL frame_vo_rise: got %b want 1", vo_b); else pass_cnt++;
            end
        end
        en_b = 1'b0;
        total_cnt += 5;
        if (fs_cnt !== 3)    $display("FAIL frame_start_count: got %0d want 3", fs_cnt); else pass_cnt++;
        if (ls_cnt !== 24)   $display("FAIL frame_ls_count: got %0d want 24", ls_cnt); else pass_cnt++;
        if (vs_low !== 30)   $display("FAIL vsync_width: got %0d want 30", vs_low); else pass_cnt++;
        if (first_vs !== 77) $display("FAIL vsync_first_tick: got %0d want 77", first_vs); else pass_cnt++;
        if (hs_low !== 3)    $display("FAIL small_hsync_width: got %0d want 3", hs_low); else pass_cnt++;
    endtask

    task automatic test_enable_gating();
        int unsigned n = 0;
        rst_n_b = 1'b0;
        tick();
        rst_n_b = 1'b1;
        tick();
        for (int unsigned c = 0; c < 520; c++) begin
            logic [11:0] ex, ey;
            logic        els, efs, ehs;
            en_b = (c % 4 == 0);
            tick();
            if (en_b) n++;
            ex  = 12'(n % 15);
            ey  = 12'((n / 15) % 8);
            els = en_b && (n % 15 == 0);
            efs = en_b && (n % 120 == 0);
            ehs = !(n >= 2 && ((n - 2) % 15) >= 10 && ((n - 2) % 15) <= 12);
            total_cnt += 5;
            if (x_b !== ex)   $display("FAIL gate_x c=%0d: got %0d want %0d", c, x_b, ex); else pass_cnt++;
            if (y_b !== ey)   $display("FAIL gate_y c=%0d: got %0d want %0d", c, y_b, ey); else pass_cnt++;
            if (ls_b !== els) $display("FAIL gate_ls c=%0d: got %b want %b", c, ls_b, els); else pass_cnt++;
            if (fs_b !== efs) $display("FAIL gate_fs c=%0d: got %b want %b", c, fs_b, efs); else pass_cnt++;
            if (hs_b !== ehs) $display("FAIL gate_hs c=%0d: got %b want %b", c, hs_b, ehs); else pass_cnt++;
        end
        en_b = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst_n_b = 1'b0;
        tick();
        rst_n_b = 1'b1;
        en_b = 1'b1;
        repeat (50) tick();
        total_cnt += 3;
        if (x_b !== 12'd5)  $display("FAIL pre_reset_x: got %0d want 5", x_b); else pass_cnt++;
        if (y_b !== 12'd3)  $display("FAIL pre_reset_y: got %0d want 3", y_b); else pass_cnt++;
        if (vo_b !== 1'b1)  $display("FAIL pre_reset_vo: got %b want 1", vo_b); else pass_cnt++;
        @(posedge clk);
        #3 rst_n_b = 1'b0;
        #1;
        total_cnt += 5;
        if (x_b !== 12'd0) $display("FAIL async_reset_x: got %0d want 0", x_b); else pass_cnt++;
        if (y_b !== 12'd0) $display("FAIL async_reset_y: got %0d want 0", y_b); else pass_cnt++;
        if (vo_b !== 1'b0) $display("FAIL async_reset_vo: got %b want 0", vo_b); else pass_cnt++;
        if (hs_b !== 1'b1) $display("FAIL async_reset_hs: got %b want 1", hs_b); else pass_cnt++;
        if (vs_b !== 1'b1) $display("FAIL async_reset_vs: got %b want 1", vs_b); else pass_cnt++;
        tick();
        tick();
        rst_n_b = 1'b1;
        for (int unsigned k = 1; k <= 120; k++) begin
            logic efs;
            tick();
            efs = (k == 120);
            total_cnt++;
            if (fs_b !== efs) $display("FAIL restart_fs k=%0d: got %b want %b", k, fs_b, efs); else pass_cnt++;
            if (k <= 3) begin
                total_cnt++;
                if (x_b !== 12'(k)) $display("FAIL restart_x k=%0d: got %0d want %0d", k, x_b, k); else pass_cnt++;
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_sync_pol();
        en_c = 1'b1;
        for (int unsigned k = 1; k <= 760; k++) begin
            tick();
            total_cnt++;
            if (vs_c !== 1'b0) $display("FAIL pol_vs k=%0d: got %b want 0", k, vs_c); else pass_cnt++;
            if (k == 639 || k == 640 || k == 655 || k == 656 || k == 751 || k == 752) begin
                logic ehs, evo;
                ehs = (k == 656 || k == 751);
                evo = (k == 639);
                total_cnt += 3;
                if (x_c !== 12'(k)) $display("FAIL pol_x k=%0d: got %0d want %0d", k, x_c, k); else pass_cnt++;
                if (hs_c !== ehs)   $display("FAIL pol_hs k=%0d: got %b want %b", k, hs_c, ehs); else pass_cnt++;
                if (vo_c !== evo)   $display("FAIL pol_vo k=%0d: got %b want %b", k, vo_c, evo); else pass_cnt++;
            end
        end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_count();
        test_frame();
        test_enable_gating();
        test_mid_reset();
        test_sync_pol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
